// File: rtl/sbio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sbio_pkg
// Description : PIN_TYPE field constants and mode decode for sb_io_model.
//               Decode of DDR output depends on SBIO_DDR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package sbio_pkg;

    typedef enum logic [1:0] {
        OE_NEVER      = 2'b00,
        OE_ALWAYS     = 2'b01,
        OE_INPUT      = 2'b10,
        OE_REGISTERED = 2'b11
    } oe_mode_t;

    typedef enum logic [1:0] {
        OUT_DDR          = 2'b00,
        OUT_REGISTERED   = 2'b01,
        OUT_SIMPLE       = 2'b10,
        OUT_REG_INVERTED = 2'b11
    } out_mode_t;

    localparam logic [5:0] PIN_NO_OUTPUT         = 6'b000000;
    localparam logic [5:0] PIN_OUTPUT_DDR        = 6'b010000;
    localparam logic [5:0] PIN_OUTPUT_REGISTERED = 6'b010100;
    localparam logic [5:0] PIN_OUTPUT_SIMPLE     = 6'b011000;
    localparam logic [5:0] PIN_OUTPUT_TRISTATE   = 6'b101000;
    localparam logic [5:0] PIN_INPUT             = 6'b000001;
    localparam logic [5:0] PIN_INPUT_REGISTERED  = 6'b000000;

    function automatic oe_mode_t oe_mode_of(input logic [5:0] pin_type);
        return oe_mode_t'(pin_type[5:4]);
    endfunction

    // Without DDR support the DDR encoding falls back to a plain output register.
    function automatic out_mode_t out_mode_of(input logic [5:0] pin_type);
`ifdef SBIO_DDR_EN
        return out_mode_t'(pin_type[3:2]);
`else
        return (pin_type[3:2] == 2'b00) ? OUT_REGISTERED : out_mode_t'(pin_type[3:2]);
`endif
    endfunction

    // Bit 1 (input latch) has no model and is treated as 0.
    function automatic logic input_is_direct(input logic [5:0] pin_type);
        return pin_type[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sbio_ddr_reg.sv
`default_nettype none
// ============================================================================
// Module      : sbio_ddr_reg
// Description : Rising/falling output register pair with clock-phase mux.
//               Falling-edge half exists only when SBIO_DDR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module sbio_ddr_reg
    import sbio_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d_rise,
    input  logic d_fall,
    output logic q_rise,
    output logic q_mux
);

    logic r_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rise <= 1'b0;
        end else if (en) begin
            r_rise <= d_rise;
        end
    end

    assign q_rise = r_rise;

`ifdef SBIO_DDR_EN
    logic r_fall;

    // Reset is sampled on the falling edge too, so the second phase clears half a cycle later.
    always_ff @(negedge clk) begin
        if (rst) begin
            r_fall <= 1'b0;
        end else if (en) begin
            r_fall <= d_fall;
        end
    end

    assign q_mux = clk ? r_rise : r_fall;
`else
    logic w_unused_fall;

    assign w_unused_fall = d_fall;
    assign q_mux         = r_rise;
`endif

endmodule
`default_nettype wire

// File: rtl/sb_io_model.sv
`default_nettype none
// ============================================================================
// Module      : sb_io_model
// Description : Behavioural I/O cell: configurable OE, output and input paths.
//               Define SBIO_DDR_EN for DDR output and falling-edge input.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_io_model
    import sbio_pkg::*;
#(
    parameter logic [5:0] PIN_TYPE = 6'b000000,
    parameter logic       PULLUP   = 1'b0
) (
    input  logic clk,
    input  logic reset_i,
    inout  wire  package_pin,
    input  logic clock_enable_i,
    input  logic output_enable_i,
    input  logic d_out_0_i,
    input  logic d_out_1_i,
    output logic d_in_0_o,
    output logic d_in_1_o
);

    localparam oe_mode_t  c_OE_MODE   = oe_mode_of(PIN_TYPE);
    localparam out_mode_t c_OUT_MODE  = out_mode_of(PIN_TYPE);
    localparam logic      c_IN_DIRECT = input_is_direct(PIN_TYPE);

    logic w_q_rise;
    logic w_q_mux;
    logic r_oe;
    logic r_din0;
    logic w_oe;
    logic w_dout;
    logic w_pad;

    sbio_ddr_reg u_ddr_reg (
        .clk    (clk),
        .rst    (reset_i),
        .en     (clock_enable_i),
        .d_rise (d_out_0_i),
        .d_fall (d_out_1_i),
        .q_rise (w_q_rise),
        .q_mux  (w_q_mux)
    );

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_oe   <= 1'b0;
            r_din0 <= 1'b0;
        end else if (clock_enable_i) begin
            r_oe   <= output_enable_i;
            r_din0 <= w_pad;
        end
    end

    always_comb begin
        w_oe = 1'b0;
        case (c_OE_MODE)
            OE_NEVER:      w_oe = 1'b0;
            OE_ALWAYS:     w_oe = 1'b1;
            OE_INPUT:      w_oe = output_enable_i;
            OE_REGISTERED: w_oe = r_oe;
            default:       w_oe = 1'b0;
        endcase
    end

    always_comb begin
        w_dout = 1'b0;
        case (c_OUT_MODE)
            OUT_DDR:          w_dout = w_q_mux;
            OUT_REGISTERED:   w_dout = w_q_rise;
            OUT_SIMPLE:       w_dout = d_out_0_i;
            OUT_REG_INVERTED: w_dout = ~w_q_rise;
            default:          w_dout = w_q_rise;
        endcase
    end

    assign package_pin = w_oe ? w_dout : 1'bz;

    // Input path always observes the resolved pad, including our own drive.
    assign w_pad = package_pin;

    generate
        if (PULLUP) begin : g_pullup
            pullup u_pullup (package_pin);
        end
    endgenerate

    assign d_in_0_o = c_IN_DIRECT ? w_pad : r_din0;

`ifdef SBIO_DDR_EN
    logic r_din1;

    always_ff @(negedge clk) begin
        if (reset_i) begin
            r_din1 <= 1'b0;
        end else if (clock_enable_i) begin
            r_din1 <= w_pad;
        end
    end

    assign d_in_1_o = r_din1;
`else
    assign d_in_1_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sb_io_model.sv
`default_nettype none
// ============================================================================
// Module      : tb_sb_io_model
// Description : Directed self-checking bench for sb_io_model; one instance per
//               pin mode sharing stimulus. Expectations follow SBIO_DDR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sb_io_model;
    import sbio_pkg::*;

`ifdef SBIO_DDR_EN
    localparam logic c_DDR_ON = 1'b1;
`else
    localparam logic c_DDR_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic ce;
    logic oe;
    logic d0;
    logic d1;

    wire pad_a, pad_b, pad_c, pad_d, pad_e, pad_f;
    logic ext_en_a, ext_val_a, ext_en_d, ext_val_d, ext_en_e, ext_val_e;

    assign pad_a = ext_en_a ? ext_val_a : 1'bz;
    assign pad_d = ext_en_d ? ext_val_d : 1'bz;
    assign pad_e = ext_en_e ? ext_val_e : 1'bz;

    logic din0_a, din1_a, din0_b, din0_e;
    logic unused_din1_b, unused_din0_c, unused_din1_c, unused_din0_d, unused_din1_d;
    logic unused_din1_e, unused_din0_f, unused_din1_f;

    int n_cmp;
    int n_err;

    always #5 clk = ~clk;

    sb_io_model #(.PIN_TYPE(PIN_OUTPUT_TRISTATE | PIN_INPUT), .PULLUP(1'b0)) u_a (
        .clk(clk), .reset_i(rst), .package_pin(pad_a), .clock_enable_i(ce),
        .output_enable_i(oe), .d_out_0_i(d0), .d_out_1_i(d1),
        .d_in_0_o(din0_a), .d_in_1_o(din1_a));

    sb_io_model #(.PIN_TYPE(PIN_OUTPUT_REGISTERED | PIN_INPUT_REGISTERED), .PULLUP(1'b0)) u_b (
        .clk(clk), .reset_i(rst), .package_pin(pad_b), .clock_enable_i(ce),
        .output_enable_i(oe), .d_out_0_i(d0), .d_out_1_i(d1),
        .d_in_0_o(din0_b), .d_in_1_o(unused_din1_b));

    sb_io_model #(.PIN_TYPE(PIN_OUTPUT_DDR), .PULLUP(1'b0)) u_c (
        .clk(clk), .reset_i(rst), .package_pin(pad_c), .clock_enable_i(ce),
        .output_enable_i(oe), .d_out_0_i(d0), .d_out_1_i(d1),
        .d_in_0_o(unused_din0_c), .d_in_1_o(unused_din1_c));

    sb_io_model #(.PIN_TYPE(6'b110100), .PULLUP(1'b0)) u_d (
        .clk(clk), .reset_i(rst), .package_pin(pad_d), .clock_enable_i(ce),
        .output_enable_i(oe), .d_out_0_i(d0), .d_out_1_i(d1),
        .d_in_0_o(unused_din0_d), .d_in_1_o(unused_din1_d));

    sb_io_model #(.PIN_TYPE(PIN_NO_OUTPUT | PIN_INPUT), .PULLUP(1'b1)) u_e (
        .clk(clk), .reset_i(rst), .package_pin(pad_e), .clock_enable_i(ce),
        .output_enable_i(oe), .d_out_0_i(d0), .d_out_1_i(d1),
        .d_in_0_o(din0_e), .d_in_1_o(unused_din1_e));

    sb_io_model #(.PIN_TYPE(6'b011100), .PULLUP(1'b0)) u_f (
        .clk(clk), .reset_i(rst), .package_pin(pad_f), .clock_enable_i(ce),
        .output_enable_i(oe), .d_out_0_i(d0), .d_out_1_i(d1),
        .d_in_0_o(unused_din0_f), .d_in_1_o(unused_din1_f));

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fall();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: time %0t exceeded limit 50000", $time);
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1; ce = 1'b1; oe = 1'b0; d0 = 1'b0; d1 = 1'b0;
        ext_en_a = 1'b0; ext_val_a = 1'b0;
        ext_en_d = 1'b0; ext_val_d = 1'b0;
        ext_en_e = 1'b0; ext_val_e = 1'b0;

        tick();
        tick();
        check_bit("rst_reg_pad", pad_b, 1'b0);
        check_bit("rst_reg_din0", din0_b, 1'b0);
        check_bit("rst_inv_pad", pad_f, 1'b1);
        check_bit("rst_din1", din1_a, 1'b0);
        check_bit("pullup_pad", pad_e, 1'b1);
        check_bit("pullup_din0", din0_e, 1'b1);
        ext_en_e = 1'b1; ext_val_e = 1'b0; #1;
        check_bit("pullup_ext0_pad", pad_e, 1'b0);
        check_bit("pullup_ext0_din0", din0_e, 1'b0);
        ext_en_e = 1'b0;

        // reset must win over active data and OE
        oe = 1'b1; d0 = 1'b1;
        tick();
        check_bit("rst_hold_reg", pad_b, 1'b0);
        ext_en_d = 1'b1; ext_val_d = 1'b0; #1;
        check_bit("rst_oe_z_lo", pad_d, 1'b0);
        ext_val_d = 1'b1; #1;
        check_bit("rst_oe_z_hi", pad_d, 1'b1);
        ext_en_d = 1'b0;
        rst = 1'b0; #1;
        check_bit("rel_reg_pre", pad_b, 1'b0);
        tick();
        check_bit("rel_oe_drive", pad_d, 1'b1);
        check_bit("rel_reg_pad", pad_b, 1'b1);
        check_bit("rel_inv_pad", pad_f, 1'b0);
        check_bit("din0_reg_lag", din0_b, 1'b0);
        tick();
        check_bit("din0_reg_cap", din0_b, 1'b1);

        d0 = 1'b0;
        tick();
        check_bit("reg_low", pad_b, 1'b0);
        d0 = 1'b1; #1;
        check_bit("reg_before_edge", pad_b, 1'b0);
        tick();
        check_bit("reg_after_edge", pad_b, 1'b1);

        ce = 1'b0; d0 = 1'b0;
        tick();
        check_bit("ce_hold_a", pad_b, 1'b1);
        d0 = 1'b1;
        tick();
        d0 = 1'b0;
        tick();
        check_bit("ce_hold_b", pad_b, 1'b1);
        check_bit("inv_ce_hold", pad_f, 1'b0);
        rst = 1'b1;
        tick();
        check_bit("rst_over_ce", pad_b, 1'b0);
        rst = 1'b0; ce = 1'b1;
        tick();

        oe = 1'b1; d0 = 1'b1; #1;
        check_bit("tri_drive_hi", pad_a, 1'b1);
        check_bit("tri_readback", din0_a, 1'b1);
        d0 = 1'b0; #1;
        check_bit("tri_drive_lo", pad_a, 1'b0);
        fall();
        oe = 1'b0; ext_en_a = 1'b1; ext_val_a = 1'b0; #1;
        check_bit("tri_ext_pad", pad_a, 1'b0);
        check_bit("tri_ext_din0", din0_a, 1'b0);
        ext_val_a = 1'b1;
        fall();
        check_bit("din1_cap_hi", din1_a, c_DDR_ON);
        ext_val_a = 1'b0; #1;
        check_bit("din1_hold", din1_a, c_DDR_ON);
        check_bit("din0_direct_lo", din0_a, 1'b0);
        fall();
        check_bit("din1_cap_lo", din1_a, 1'b0);
        ce = 1'b0; ext_val_a = 1'b1;
        fall();
        check_bit("din1_ce_hold", din1_a, 1'b0);
        ce = 1'b1; ext_en_a = 1'b0;

        tick();
        d0 = 1'b1; d1 = 1'b1;
        tick();
        check_bit("ddr_hi_11", pad_c, 1'b1);
        fall();
        check_bit("ddr_lo_11", pad_c, 1'b1);
        rst = 1'b1;
        tick();
        check_bit("ddr_rst_hi", pad_c, 1'b0);
        fall();
        check_bit("ddr_rst_lo", pad_c, 1'b0);
        rst = 1'b0; d0 = 1'b0; d1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_bit("ddr_fwd_hi", pad_c, 1'b0);
            fall();
            check_bit("ddr_fwd_lo", pad_c, c_DDR_ON);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
